// File: rtl/i2c_cond_gen.sv
// I2C master bus-condition generator: drives START, repeated START and STOP onto open-drain SCL/SDA.
// Optional macro STRETCH_TIMEOUT_EN aborts a command when a slave stretches SCL for TO_CYC cycles.
module i2c_cond_gen #(
  parameter int T_QTR  = 4,
  parameter int TO_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       done,
  output logic       err,
  output logic       held,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam logic [1:0]  CMD_START     = 2'b01;
  localparam logic [1:0]  CMD_RSTART    = 2'b10;
  localparam logic [1:0]  CMD_STOP      = 2'b11;
  localparam logic [15:0] CNT_LOAD      = 16'(T_QTR - 1);
  localparam logic [15:0] CNT_WAIT_LOAD = 16'(T_QTR - 2);

  typedef enum logic [3:0] {
    IDLE,
    ST_P1, ST_P2, ST_P3,
    RS_P1, RS_WAIT, RS_P2, RS_P3, RS_P4,
    SP_P1, SP_WAIT, SP_P2, SP_P3, SP_P4
  } state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic        phase_end;
  logic        arb_lost;

  assign cmd_ready = (state_reg == IDLE);
  assign phase_end = (cnt_reg == 16'd0);
  assign arb_lost  = ~sda_oe & scl_in & ~sda_in;

`ifdef STRETCH_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            to_expired;

  assign to_expired = ~scl_in & (to_cnt_reg == TO_LAST);
`else
  // TO_CYC only matters when the stretch timeout is built in.
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      held      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef STRETCH_TIMEOUT_EN
      to_cnt_reg <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!phase_end) cnt_reg <= cnt_reg - 16'd1;
`ifdef STRETCH_TIMEOUT_EN
      if (state_reg == RS_WAIT || state_reg == SP_WAIT) to_cnt_reg <= to_cnt_reg + TO_W'(1);
      else                                              to_cnt_reg <= '0;
`endif
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            cnt_reg <= CNT_LOAD;
            case (cmd)
              CMD_START: begin
                if (!held && scl_in && sda_in) state_reg <= ST_P1;
                else                           err       <= 1'b1;
              end
              CMD_RSTART: begin
                if (held) begin
                  state_reg <= RS_P1;
                  sda_oe    <= 1'b0;
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_STOP: begin
                if (held) begin
                  state_reg <= SP_P1;
                  sda_oe    <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        ST_P1: if (phase_end) begin state_reg <= ST_P2; cnt_reg <= CNT_LOAD; sda_oe <= 1'b1; end
        ST_P2: if (phase_end) begin state_reg <= ST_P3; cnt_reg <= CNT_LOAD; scl_oe <= 1'b1; end
        ST_P3: if (phase_end) begin state_reg <= IDLE;  held <= 1'b1; done <= 1'b1; end
        RS_P1: if (phase_end) begin state_reg <= RS_WAIT; scl_oe <= 1'b0; end
        SP_P1: if (phase_end) begin state_reg <= SP_WAIT; scl_oe <= 1'b0; end
        RS_WAIT, SP_WAIT: begin
          if (scl_in) begin
            // The edge that first sees SCL high already counts as the first high-phase cycle.
            state_reg <= (state_reg == RS_WAIT) ? RS_P2 : SP_P2;
            cnt_reg   <= CNT_WAIT_LOAD;
          end
`ifdef STRETCH_TIMEOUT_EN
          else if (to_expired) begin
            state_reg <= IDLE;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            held      <= 1'b0;
            err       <= 1'b1;
          end
`endif
        end
        RS_P2: begin
          if (phase_end) begin
            if (arb_lost) begin
              state_reg <= IDLE;
              scl_oe    <= 1'b0;
              sda_oe    <= 1'b0;
              held      <= 1'b0;
              err       <= 1'b1;
            end else begin
              state_reg <= RS_P3;
              cnt_reg   <= CNT_LOAD;
              sda_oe    <= 1'b1;
            end
          end
        end
        RS_P3: if (phase_end) begin state_reg <= RS_P4; cnt_reg <= CNT_LOAD; scl_oe <= 1'b1; end
        RS_P4: if (phase_end) begin state_reg <= IDLE;  done <= 1'b1; end
        SP_P2: if (phase_end) begin state_reg <= SP_P3; cnt_reg <= CNT_LOAD; sda_oe <= 1'b0; end
        SP_P3: begin
          if (phase_end) begin
            if (arb_lost) begin
              state_reg <= IDLE;
              scl_oe    <= 1'b0;
              sda_oe    <= 1'b0;
              held      <= 1'b0;
              err       <= 1'b1;
            end else begin
              state_reg <= SP_P4;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        SP_P4: if (phase_end) begin state_reg <= IDLE; held <= 1'b0; done <= 1'b1; end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cond_gen.sv
// Randomized scoreboard bench for i2c_cond_gen: expected pulses are queued at issue time
// and popped by an independent monitor; line waveforms are predicted from phase arithmetic.
module tb_i2c_cond_gen;

  localparam int T      = 4;
  localparam int TO_CYC = 1024;
  localparam logic [1:0] C_START  = 2'b01;
  localparam logic [1:0] C_RSTART = 2'b10;
  localparam logic [1:0] C_STOP   = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready, done, err, held, scl_in, sda_in, scl_oe, sda_oe;
  logic       slave_hold = 1'b0;
  logic       sda_force = 1'b0;

  // Open-drain bus: a line is high unless somebody pulls it low.
  assign scl_in = ~scl_oe & ~slave_hold;
  assign sda_in = ~sda_oe & ~sda_force;

  i2c_cond_gen #(.T_QTR(T), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .done(done), .err(err), .held(held),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int at;
    bit scl;
    bit sda;
    bit hld;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  bit   m_held = 1'b0;
  bit   m_scl  = 1'b0;
  bit   m_sda  = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      check("done_err_exclusive", int'(done && err), 0);
      check("pulse_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        $display("txn: %s at edge %0d (exp %s at %0d) scl_oe=%0d sda_oe=%0d held=%0d",
                 err ? "err" : "done", edge_cnt, mon_e.is_err ? "err" : "done", mon_e.at,
                 scl_oe, sda_oe, held);
        check("pulse_kind", int'(err), int'(mon_e.is_err));
        check("pulse_edge", edge_cnt, mon_e.at);
        check("scl_oe_after", int'(scl_oe), int'(mon_e.scl));
        check("sda_oe_after", int'(sda_oe), int'(mon_e.sda));
        check("held_after", int'(held), int'(mon_e.hld));
        check("ready_at_pulse", int'(cmd_ready), 1);
      end
    end
  end

  // Line pattern k cycles after the accept edge, s = stretch cycles in the SCL wait.
  function automatic void exp_trace(input logic [1:0] c, input int k, input int s,
                                    output bit scl, output bit sda);
    scl = 1'b0;
    sda = 1'b0;
    case (c)
      C_START: begin
        scl = (k >= 2*T);
        sda = (k >= T);
      end
      C_RSTART: begin
        scl = (k < T) || (k >= 3*T + s);
        sda = (k >= 2*T + s);
      end
      C_STOP: begin
        scl = (k < T);
        sda = (k < 2*T + s);
      end
      default: ;
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] c, input int s_in, input bit fs, input bit arb);
    exp_t e;
    bit   legal, es, ed, do_arb;
    int   s, lat, k;
    check("ready_before_cmd", int'(cmd_ready), 1);
    if (fs) sda_force = 1'b1;
    case (c)
      C_START:          legal = !m_held && !m_scl && !(m_sda || fs);
      C_RSTART, C_STOP: legal = m_held;
      default:          legal = 1'b0;
    endcase
    s      = (legal && c != C_START) ? s_in : 0;
    do_arb = legal && arb && (c == C_STOP);
    lat    = 0;
    e.is_err = 1'b1; e.scl = m_scl; e.sda = m_sda; e.hld = m_held;
    if (legal) begin
      case (c)
        C_START:  begin lat = 3*T;     e.is_err = 1'b0; e.scl = 1'b1; e.sda = 1'b1; e.hld = 1'b1; end
        C_RSTART: begin lat = 4*T + s; e.is_err = 1'b0; e.scl = 1'b1; e.sda = 1'b1; e.hld = 1'b1; end
        default: begin
          lat = do_arb ? 3*T + s : 4*T + s;
          e.is_err = do_arb; e.scl = 1'b0; e.sda = 1'b0; e.hld = 1'b0;
        end
      endcase
`ifdef STRETCH_TIMEOUT_EN
      if (c != C_START && s >= TO_CYC) begin
        lat = T + TO_CYC;
        e.is_err = 1'b1; e.scl = 1'b0; e.sda = 1'b0; e.hld = 1'b0;
      end
`endif
    end
    e.at = edge_cnt + 1 + lat;
    sb.push_back(e);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!cmd_ready) begin
      if (k > lat + 50) begin
        check("cmd_timeout", k, lat);
        finish_run();
      end
      exp_trace(c, k, s, es, ed);
      if (legal && k < lat) begin
        check("trace_scl_oe", int'(scl_oe), int'(es));
        check("trace_sda_oe", int'(sda_oe), int'(ed));
      end
      slave_hold = (k >= T) && (k < T + s);
      if (do_arb && k == 2*T + s + 1) sda_force = 1'b1;
      // Requests while busy must be ignored.
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd = 2'($urandom_range(0, 3));
      @(negedge clk);
      k++;
    end
    cmd_valid  = 1'b0;
    slave_hold = 1'b0;
    sda_force  = 1'b0;
    m_held = e.hld;
    m_scl  = e.scl;
    m_sda  = e.sda;
  endtask

  task automatic reset_mid();
    if (!m_held) run_cmd(C_START, 0, 1'b0, 1'b0);
    cmd = C_STOP;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2*T) @(negedge clk);
    check("mid_op_busy", int'(cmd_ready), 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_scl_oe", int'(scl_oe), 0);
    check("async_rst_sda_oe", int'(sda_oe), 0);
    check("async_rst_held", int'(held), 0);
    check("async_rst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_held = 1'b0; m_scl = 1'b0; m_sda = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] rc;
    repeat (3) @(negedge clk);
    check("rst_scl_oe", int'(scl_oe), 0);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_held", int'(held), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(C_START,  0,    1'b0, 1'b0);
    run_cmd(C_RSTART, 0,    1'b0, 1'b0);
    run_cmd(C_STOP,   10,   1'b0, 1'b0);
    run_cmd(C_START,  0,    1'b1, 1'b0);
    run_cmd(C_STOP,   0,    1'b0, 1'b0);
    run_cmd(2'b00,    0,    1'b0, 1'b0);
    run_cmd(C_START,  0,    1'b0, 1'b0);
    run_cmd(C_STOP,   3,    1'b0, 1'b1);
    run_cmd(C_START,  0,    1'b0, 1'b0);
    run_cmd(C_RSTART, 1100, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rc = 2'($urandom_range(0, 3));
      run_cmd(rc,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0,
              (rc == C_START) && ($urandom_range(0, 3) == 0),
              (rc == C_STOP) && ($urandom_range(0, 3) == 0));
    end

    reset_mid();
    run_cmd(C_START, 0, 1'b0, 1'b0);
    run_cmd(C_STOP,  2, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    finish_run();
  end

endmodule
